add_sub_align_unit: RTL

Pre-adder alignment stage of the FPU add/sub datapath: the right-shift counterpart to post-add normalization. Takes two unpacked operands, orders them by magnitude, and right-shifts the smaller mantissa by the exponent difference, folding shifted-out bits into a sticky LSB. The adder and normalization stage consume its output. Two-stage elastic pipeline with valid/ready on both sides.

---
 rtl/add_sub_align_unit_if.sv | 39 +++
 rtl/add_sub_align_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/add_sub_align_unit_if.sv
// Handshake and operand/result bundle for the add/sub alignment stage.
// The master side supplies operands and accepts results; the slave side is the aligner.
interface add_sub_align_unit_if #(
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_MAN  = 24,
    parameter int SIZE_DATA = 27
) ();
    logic                 i_valid;
    logic                 o_ready;
    logic                 i_sign_a;
    logic                 i_sign_b;
    logic [SIZE_EXP-1:0]  i_exp_a;
    logic [SIZE_EXP-1:0]  i_exp_b;
    logic [SIZE_MAN-1:0]  i_man_a;
    logic [SIZE_MAN-1:0]  i_man_b;
    logic                 o_valid;
    logic                 i_ready;
    logic [SIZE_EXP-1:0]  o_exp;
    logic                 o_sign_big;
    logic                 o_sign_small;
    logic [SIZE_DATA-1:0] o_man_big;
    logic [SIZE_DATA-1:0] o_man_small;
    logic                 o_swap;
    logic                 o_shift_sat;

    modport master (
        output i_valid, i_sign_a, i_sign_b, i_exp_a, i_exp_b,
        output i_man_a, i_man_b, i_ready,
        input  o_ready, o_valid, o_exp, o_sign_big, o_sign_small,
        input  o_man_big, o_man_small, o_swap, o_shift_sat
    );

    modport slave (
        input  i_valid, i_sign_a, i_sign_b, i_exp_a, i_exp_b,
        input  i_man_a, i_man_b, i_ready,
        output o_ready, o_valid, o_exp, o_sign_big, o_sign_small,
        output o_man_big, o_man_small, o_swap, o_shift_sat
    );
endinterface

// File: rtl/add_sub_align_unit.sv
// FPU add/sub pre-adder alignment: compare/swap stage, then right-shift stage.
// Define ALIGN_STICKY_EN to fold shifted-out bits into the LSB of o_man_small.
module add_sub_align_unit #(
    parameter int SIZE_EXP   = 8,
    parameter int SIZE_MAN   = 24,
    parameter int SIZE_DATA  = 27,
    parameter int SIZE_SHIFT = 5
) (
    input logic i_clk,
    input logic i_rst,
    add_sub_align_unit_if.slave bus
);

    typedef struct packed {
        logic                  sign_big;
        logic                  sign_small;
        logic [SIZE_EXP-1:0]   exp_big;
        logic [SIZE_MAN-1:0]   man_big;
        logic [SIZE_MAN-1:0]   man_small;
        logic [SIZE_SHIFT-1:0] d;
        logic                  sat;
        logic                  swap;
    } s1_t;

    typedef struct packed {
        logic [SIZE_EXP-1:0]  exp_big;
        logic                 sign_big;
        logic                 sign_small;
        logic [SIZE_DATA-1:0] man_big;
        logic [SIZE_DATA-1:0] man_small;
        logic                 swap;
        logic                 sat;
    } s2_t;

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_ld;
    logic                 s2_ld;
    s1_t                  s1_d;
    s1_t                  s1_q;
    s2_t                  s2_d;
    s2_t                  s2_q;
    logic                 a_big;
    logic [SIZE_EXP-1:0]  diff;
    logic [SIZE_DATA-1:0] ext;
    logic [SIZE_DATA-1:0] shifted;

    // Elastic handshake: each stage reloads when empty or draining this cycle.
    assign s2_ld       = !s2_valid || bus.i_ready;
    assign s1_ld       = !s1_valid || s2_ld;
    assign bus.o_ready = !i_rst && s1_ld;
    assign bus.o_valid = s2_valid;

    always_comb begin
        a_big = (bus.i_exp_a > bus.i_exp_b) ||
                ((bus.i_exp_a == bus.i_exp_b) && (bus.i_man_a >= bus.i_man_b));
        diff = '0;
        s1_d = '0;
        if (a_big) begin
            diff            = bus.i_exp_a - bus.i_exp_b;
            s1_d.sign_big   = bus.i_sign_a;
            s1_d.sign_small = bus.i_sign_b;
            s1_d.exp_big    = bus.i_exp_a;
            s1_d.man_big    = bus.i_man_a;
            s1_d.man_small  = bus.i_man_b;
        end else begin
            diff            = bus.i_exp_b - bus.i_exp_a;
            s1_d.sign_big   = bus.i_sign_b;
            s1_d.sign_small = bus.i_sign_a;
            s1_d.exp_big    = bus.i_exp_b;
            s1_d.man_big    = bus.i_man_b;
            s1_d.man_small  = bus.i_man_a;
        end
        s1_d.swap = !a_big;
        s1_d.sat  = diff >= SIZE_EXP'(SIZE_DATA);
        // Low bits suffice: larger differences take the saturation path.
        s1_d.d    = diff[SIZE_SHIFT-1:0];
    end

    always_comb begin
        ext     = {s1_q.man_small, 3'b000};
        shifted = ext >> s1_q.d;
        s2_d    = '0;
        s2_d.exp_big    = s1_q.exp_big;
        s2_d.sign_big   = s1_q.sign_big;
        s2_d.sign_small = s1_q.sign_small;
        s2_d.man_big    = {s1_q.man_big, 3'b000};
        s2_d.swap       = s1_q.swap;
        s2_d.sat        = s1_q.sat;
`ifdef ALIGN_STICKY_EN
        if (s1_q.sat) begin
            s2_d.man_small = {{(SIZE_DATA-1){1'b0}}, |s1_q.man_small};
        end else begin
            s2_d.man_small    = shifted;
            s2_d.man_small[0] = shifted[0] |
                                (|(ext & ~({SIZE_DATA{1'b1}} << s1_q.d)));
        end
`else
        s2_d.man_small = s1_q.sat ? '0 : shifted;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_ld) begin
                s1_valid <= bus.i_valid;
                if (bus.i_valid) s1_q <= s1_d;
            end
            if (s2_ld) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_q <= s2_d;
            end
        end
    end

    assign bus.o_exp        = s2_q.exp_big;
    assign bus.o_sign_big   = s2_q.sign_big;
    assign bus.o_sign_small = s2_q.sign_small;
    assign bus.o_man_big    = s2_q.man_big;
    assign bus.o_man_small  = s2_q.man_small;
    assign bus.o_swap       = s2_q.swap;
    assign bus.o_shift_sat  = s2_q.sat;

endmodule
